reg_writeback: RTL and testbench
================================

# reg_writeback

Write-back arbiter that sits directly upstream of the 4-entry register file and drives its write side (WriteEn, MovEn, Waddr, DataIn). It merges three result sources: single-cycle ALU results, move-immediate operations, and multi-cycle data-memory loads. It also tracks one outstanding load in a scoreboard, so decode can stall on read-after-write (RAW) and write-after-write (WAW) hazards. All register-file-facing outputs are registered.

## Interface
- W, 8, data path width (matches register file)
- A, 2, register address width; register count is 2**A
- LAT, 2, data-memory load latency in cycles, legal range 1..4
- Clk  in  1  clock, rising-edge active
- Reset  in  1  asynchronous, active-low reset
- AluValid  in  1  ALU result present this cycle
- AluDest  in  A  ALU destination register
- AluData  in  W  ALU result
- MovValid  in  1  move-immediate present this cycle (immediate travels on the register file's RaddrA/RaddrB)
- MovDest  in  A  move destination register
- LoadValid  in  1  load issue request
- LoadDest  in  A  load destination register
- LoadReady  out  1  load can be accepted this cycle
- MemRdata  in  W  memory read data, valid exactly LAT cycles after load accept
- Stall  out  1  combinational; ALU/MOV request not taken this cycle, upstream holds it
- Busy  out  2**A  scoreboard, one bit per register with a pending load
- WriteEn  out  1  register file write enable
- MovEn  out  1  register file move enable
- Waddr  out  A  register file write address
- DataIn  out  W  register file write data

## Operation
- FSM states:
  - IDLE: LoadReady=1. LoadValid moves to WAIT, latches LoadDest, sets Busy[LoadDest], and loads the counter with LAT-1.
  - WAIT: LoadReady=0. The counter decrements each cycle. When counter=0, the next edge captures MemRdata, writes it back, clears the Busy bit, and returns to IDLE.
- Only one load is outstanding at a time. LoadValid while LoadReady=0 is ignored, and upstream must hold it.
- Load return cycle = WAIT with counter=0.
- Write-back priority at each edge:
  - Load return is highest and never stalls.
  - ALU is next.
  - MOV is lowest.
- Stall=1 when any of these holds:
  - (AluValid|MovValid) during the load return cycle.
  - AluValid & Busy[AluDest].
  - MovValid & Busy[MovDest].
  - AluValid & MovValid (MOV stalled, ALU proceeds).
- A request that is not stalled is taken at the edge. Its write appears in the next cycle.
- ALU write: WriteEn=1, MovEn=0, Waddr=AluDest, DataIn=AluData.
- MOV write: MovEn=1, WriteEn=0, Waddr=MovDest, DataIn=0.
- Load write: WriteEn=1, MovEn=0, Waddr=latched dest, DataIn=MemRdata.
- WriteEn and MovEn are never both 1. Both are 0 in cycles with no taken request.
- A load may be accepted in the same cycle as a taken ALU/MOV to the same register. Order is preserved because the ALU/MOV write lands first.
- Busy is one-hot or zero.
- RAW stalls on Busy are the decode stage's responsibility. This block only reports Busy.

## Timing
- Reset asserted (low): asynchronously forces
  - state=IDLE, counter=0, Busy=0
  - WriteEn=0, MovEn=0, Waddr=0, DataIn=0
  - LoadReady=1, Stall=0
- Reset mid-load discards the load. The MemRdata that follows is ignored and no write occurs.
- ALU/MOV latency: 1 cycle from the taken cycle to the register file write cycle.
- Load timing, with accept at cycle 0:
  - Busy[dest]=1 and LoadReady=0 during cycles 1..LAT.
  - MemRdata is sampled at the end of cycle LAT.
  - The write occurs in cycle LAT+1, with Busy cleared and LoadReady=1 in that same cycle.
  - Back-to-back loads: the next load can be accepted in cycle LAT+1.
- LAT=1: WAIT lasts one cycle and the counter is never decremented.
- Stall depends only on current inputs, state and Busy. It has no path from LoadValid.
- Upstream keeps a stalled AluValid/MovValid and its payload stable until Stall=0.

## Test plan
- Reset: hold Reset low 3 cycles with random inputs -> all outputs 0 except LoadReady=1; Busy=0000.
- ALU write: AluValid, AluDest=2, AluData=0xA5 in cycle 5 -> cycle 6 has WriteEn=1, Waddr=2, DataIn=0xA5; cycle 7 WriteEn=0. Then MovValid, MovDest=3 -> MovEn=1, Waddr=3 one cycle later.
- Load, LAT=2: LoadValid, LoadDest=1 at cycle 0 -> Busy=0010 and LoadReady=0 in cycles 1-2; MemRdata=0x3C in cycle 2 -> cycle 3 has WriteEn=1, Waddr=1, DataIn=0x3C, Busy=0000.
- Return collision: during the above load, AluValid, AluDest=3, AluData=0x11 held from cycle 2 -> Stall=1 in cycle 2, Stall=0 in cycle 3, ALU write in cycle 4.
- WAW and dual request: AluValid, AluDest=1 while Busy[1]=1 -> Stall=1 until the load write cycle. AluValid and MovValid together with no load -> ALU written next cycle, MOV written the cycle after.
- Reset mid-load: drive Reset low in cycle 1 of a LAT=3 load, release in cycle 2 -> no WriteEn through cycle 6, Busy=0000, LoadReady=1.

Source files
------------

// File: rtl/reg_writeback.sv
// reg_writeback: write-back arbiter in front of the register file.
// It merges ALU results, move-immediates and multi-cycle loads into one
// registered write port. It also keeps a one-entry load scoreboard (Busy)
// so that decode can detect RAW/WAW hazards against the pending load.
module reg_writeback #(
    parameter int W   = 8,
    parameter int A   = 2,
    parameter int LAT = 2   // load latency, legal range 1..4
) (
    input  logic                Clk,
    input  logic                Reset,      // asynchronous, active-low
    input  logic                AluValid,
    input  logic [A-1:0]        AluDest,
    input  logic [W-1:0]        AluData,
    input  logic                MovValid,
    input  logic [A-1:0]        MovDest,
    input  logic                LoadValid,
    input  logic [A-1:0]        LoadDest,
    output logic                LoadReady,
    input  logic [W-1:0]        MemRdata,
    output logic                Stall,
    output logic [(2**A)-1:0]   Busy,
    output logic                WriteEn,
    output logic                MovEn,
    output logic [A-1:0]        Waddr,
    output logic [W-1:0]        DataIn
);

    localparam int NREG = 2**A;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // The counter only ever holds LAT-1 down to 0, so two bits cover LAT<=4.
    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    logic [0:0]      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [A-1:0]    load_dest_q, load_dest_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            write_en_q, write_en_d;
    logic            mov_en_q, mov_en_d;
    logic [A-1:0]    waddr_q, waddr_d;
    logic [W-1:0]    data_in_q, data_in_d;

    logic load_return;
    logic alu_take;
    logic mov_take;

    // Decode the load return slot and which ALU/MOV request wins this cycle.
    // The load return owns the write port outright; ALU beats MOV; a request
    // whose destination still has a pending load waits (WAW ordering).
    always_comb begin
        load_return = (state_q == ST_WAIT) && (cnt_q == 2'd0);
        alu_take    = AluValid && !load_return && !busy_q[AluDest];
        mov_take    = MovValid && !AluValid && !load_return && !busy_q[MovDest];
        Stall       = Reset &&
                      (((AluValid || MovValid) && load_return) ||
                       (AluValid && busy_q[AluDest]) ||
                       (MovValid && busy_q[MovDest]) ||
                       (AluValid && MovValid));
    end

    // Load FSM, latency counter, scoreboard and write-port next state.
    // Busy is set when a load is accepted, so an ALU/MOV to the same
    // register in that same cycle still goes ahead and lands first.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_dest_d = load_dest_q;
        busy_d      = busy_q;
        write_en_d  = 1'b0;
        mov_en_d    = 1'b0;
        waddr_d     = waddr_q;
        data_in_d   = data_in_q;

        case (state_q)
            ST_IDLE: begin
                if (LoadValid) begin
                    state_d          = ST_WAIT;
                    cnt_d            = CNT_INIT;
                    load_dest_d      = LoadDest;
                    busy_d           = '0;
                    busy_d[LoadDest] = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                    busy_d  = '0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_return) begin
            write_en_d = 1'b1;
            waddr_d    = load_dest_q;
            data_in_d  = MemRdata;
        end else if (alu_take) begin
            write_en_d = 1'b1;
            waddr_d    = AluDest;
            data_in_d  = AluData;
        end else if (mov_take) begin
            mov_en_d   = 1'b1;
            waddr_d    = MovDest;
            data_in_d  = '0;
        end
    end

    // State and registered register-file outputs; reset discards any pending load.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            load_dest_q <= '0;
            busy_q      <= '0;
            write_en_q  <= 1'b0;
            mov_en_q    <= 1'b0;
            waddr_q     <= '0;
            data_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_dest_q <= load_dest_d;
            busy_q      <= busy_d;
            write_en_q  <= write_en_d;
            mov_en_q    <= mov_en_d;
            waddr_q     <= waddr_d;
            data_in_q   <= data_in_d;
        end
    end

    assign LoadReady = (state_q == ST_IDLE);
    assign Busy      = busy_q;
    assign WriteEn   = write_en_q;
    assign MovEn     = mov_en_q;
    assign Waddr     = waddr_q;
    assign DataIn    = data_in_q;

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed bench for reg_writeback. Two instances share
// the stimulus: a LAT=2 one for the main checks and a LAT=3 one for the
// longer-latency and reset-during-load checks.
module tb_reg_writeback;

    logic       clk;
    logic       rstN;
    logic       aluValid;
    logic [1:0] aluDest;
    logic [7:0] aluData;
    logic       movValid;
    logic [1:0] movDest;
    logic       loadValid;
    logic [1:0] loadDest;
    logic [7:0] memRdata;

    logic       loadReady, stall, writeEn, movEn;
    logic [3:0] busy;
    logic [1:0] waddr;
    logic [7:0] dataIn;

    logic       loadReadyL3, stallL3, writeEnL3, movEnL3;
    logic [3:0] busyL3;
    logic [1:0] waddrL3;
    logic [7:0] dataInL3;

    int assertCount = 0;
    int failCount   = 0;

    reg_writeback #(.W(8), .A(2), .LAT(2)) u_dut (
        .Clk(clk), .Reset(rstN),
        .AluValid(aluValid), .AluDest(aluDest), .AluData(aluData),
        .MovValid(movValid), .MovDest(movDest),
        .LoadValid(loadValid), .LoadDest(loadDest), .LoadReady(loadReady),
        .MemRdata(memRdata), .Stall(stall), .Busy(busy),
        .WriteEn(writeEn), .MovEn(movEn), .Waddr(waddr), .DataIn(dataIn)
    );

    reg_writeback #(.W(8), .A(2), .LAT(3)) u_dut3 (
        .Clk(clk), .Reset(rstN),
        .AluValid(aluValid), .AluDest(aluDest), .AluData(aluData),
        .MovValid(movValid), .MovDest(movDest),
        .LoadValid(loadValid), .LoadDest(loadDest), .LoadReady(loadReadyL3),
        .MemRdata(memRdata), .Stall(stallL3), .Busy(busyL3),
        .WriteEn(writeEnL3), .MovEn(movEnL3), .Waddr(waddrL3), .DataIn(dataInL3)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive every input for the current cycle and let combinational outputs settle.
    task automatic applyStimulus(input logic av, input logic [1:0] ad,
                                 input logic [7:0] adata, input logic mv,
                                 input logic [1:0] md, input logic lv,
                                 input logic [1:0] ld, input logic [7:0] mrd);
        aluValid  = av;
        aluDest   = ad;
        aluData   = adata;
        movValid  = mv;
        movDest   = md;
        loadValid = lv;
        loadDest  = ld;
        memRdata  = mrd;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);
    endtask

    // Directed sequence; cycle numbers in comments are relative to each scenario.
    initial begin
        rstN = 1'b0;
        idle();

        // Reset held for three cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom),
                          2'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
            checkOutput("reset_stall", stall, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 2'd1, 8'hFF, 1'b1, 2'd2, 1'b1, 2'd3, 8'hFF);
        checkOutput("reset_stall_both", stall, 1'b0);
        checkOutput("reset_writeEn", writeEn, 1'b0);
        checkOutput("reset_movEn", movEn, 1'b0);
        checkOutput("reset_waddr", waddr, 2'd0);
        checkOutput("reset_dataIn", dataIn, 8'h00);
        checkOutput("reset_loadReady", loadReady, 1'b1);
        checkOutput("reset_busy", busy, 4'b0000);
        idle();
        rstN = 1'b1;
        nextCycle();
        nextCycle();

        // ALU write then MOV write.
        applyStimulus(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);
        checkOutput("alu_stall", stall, 1'b0);
        nextCycle();
        idle();
        checkOutput("alu_writeEn", writeEn, 1'b1);
        checkOutput("alu_movEn", movEn, 1'b0);
        checkOutput("alu_waddr", waddr, 2'd2);
        checkOutput("alu_dataIn", dataIn, 8'hA5);
        nextCycle();
        checkOutput("alu_writeEn_off", writeEn, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00);
        checkOutput("mov_stall", stall, 1'b0);
        nextCycle();
        idle();
        checkOutput("mov_movEn", movEn, 1'b1);
        checkOutput("mov_writeEn", writeEn, 1'b0);
        checkOutput("mov_waddr", waddr, 2'd3);
        checkOutput("mov_dataIn", dataIn, 8'h00);
        nextCycle();
        checkOutput("mov_movEn_off", movEn, 1'b0);
        nextCycle();
        nextCycle();

        // LAT=2 load to r1 with an ALU request colliding with the return cycle.
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 2'd1, 8'h00);   // cycle 0
        checkOutput("ld_ready_c0", loadReady, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 2'd2, 8'h00);   // cycle 1, ignored load
        checkOutput("ld_busy_c1", busy, 4'b0010);
        checkOutput("ld_ready_c1", loadReady, 1'b0);
        checkOutput("ld_writeEn_c1", writeEn, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 2'd3, 8'h11, 1'b0, 2'd0, 1'b0, 2'd0, 8'h3C);   // cycle 2
        checkOutput("ld_busy_c2", busy, 4'b0010);
        checkOutput("ld_ready_c2", loadReady, 1'b0);
        checkOutput("ret_stall_c2", stall, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 2'd3, 8'h11, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);   // cycle 3
        checkOutput("ld_writeEn_c3", writeEn, 1'b1);
        checkOutput("ld_waddr_c3", waddr, 2'd1);
        checkOutput("ld_dataIn_c3", dataIn, 8'h3C);
        checkOutput("ld_busy_c3", busy, 4'b0000);
        checkOutput("ld_ready_c3", loadReady, 1'b1);
        checkOutput("ret_stall_c3", stall, 1'b0);
        nextCycle();
        idle();                                                            // cycle 4
        checkOutput("ret_alu_writeEn", writeEn, 1'b1);
        checkOutput("ret_alu_waddr", waddr, 2'd3);
        checkOutput("ret_alu_dataIn", dataIn, 8'h11);
        nextCycle();
        nextCycle();
        nextCycle();

        // WAW: ALU to r1 while a load to r1 is pending.
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 2'd1, 8'h00);   // cycle 0
        nextCycle();
        applyStimulus(1'b1, 2'd1, 8'h77, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);   // cycle 1
        checkOutput("waw_stall_c1", stall, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 2'd1, 8'h77, 1'b0, 2'd0, 1'b0, 2'd0, 8'h55);   // cycle 2
        checkOutput("waw_stall_c2", stall, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 2'd1, 8'h77, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);   // cycle 3
        checkOutput("waw_stall_c3", stall, 1'b0);
        checkOutput("waw_ld_dataIn", dataIn, 8'h55);
        checkOutput("waw_ld_waddr", waddr, 2'd1);
        nextCycle();
        idle();                                                            // cycle 4
        checkOutput("waw_alu_writeEn", writeEn, 1'b1);
        checkOutput("waw_alu_dataIn", dataIn, 8'h77);
        nextCycle();
        nextCycle();
        nextCycle();

        // ALU and MOV together: ALU next cycle, MOV the cycle after.
        applyStimulus(1'b1, 2'd0, 8'h22, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00);
        checkOutput("dual_stall", stall, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00);
        checkOutput("dual_stall_mov", stall, 1'b0);
        checkOutput("dual_alu_writeEn", writeEn, 1'b1);
        checkOutput("dual_alu_movEn", movEn, 1'b0);
        checkOutput("dual_alu_waddr", waddr, 2'd0);
        checkOutput("dual_alu_dataIn", dataIn, 8'h22);
        nextCycle();
        idle();
        checkOutput("dual_mov_movEn", movEn, 1'b1);
        checkOutput("dual_mov_writeEn", writeEn, 1'b0);
        checkOutput("dual_mov_waddr", waddr, 2'd2);
        nextCycle();
        checkOutput("dual_quiet_movEn", movEn, 1'b0);
        checkOutput("dual_quiet_writeEn", writeEn, 1'b0);
        nextCycle();
        nextCycle();

        // Load accepted alongside an ALU write to the same register.
        applyStimulus(1'b1, 2'd2, 8'h99, 1'b0, 2'd0, 1'b1, 2'd2, 8'h00);   // cycle 0
        checkOutput("same_stall", stall, 1'b0);
        nextCycle();
        idle();                                                            // cycle 1
        checkOutput("same_alu_writeEn", writeEn, 1'b1);
        checkOutput("same_alu_dataIn", dataIn, 8'h99);
        checkOutput("same_busy", busy, 4'b0100);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 8'h44);   // cycle 2
        nextCycle();
        idle();                                                            // cycle 3
        checkOutput("same_ld_writeEn", writeEn, 1'b1);
        checkOutput("same_ld_waddr", waddr, 2'd2);
        checkOutput("same_ld_dataIn", dataIn, 8'h44);
        nextCycle();
        nextCycle();
        nextCycle();

        // LAT=3 load to r0: busy cycles 1..3, data sampled at end of cycle 3.
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 2'd0, 8'h00);   // cycle 0
        nextCycle();
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0,
                          (c == 3) ? 8'hC3 : 8'h00);
            checkOutput("l3_busy", busyL3, 4'b0001);
            checkOutput("l3_ready", loadReadyL3, 1'b0);
            checkOutput("l3_writeEn", writeEnL3, 1'b0);
            nextCycle();
        end
        idle();                                                            // cycle 4
        checkOutput("l3_ld_writeEn", writeEnL3, 1'b1);
        checkOutput("l3_ld_waddr", waddrL3, 2'd0);
        checkOutput("l3_ld_dataIn", dataInL3, 8'hC3);
        checkOutput("l3_ld_busy", busyL3, 4'b0000);
        checkOutput("l3_ld_ready", loadReadyL3, 1'b1);
        nextCycle();
        nextCycle();
        nextCycle();

        // LAT=3 load to r3 interrupted by reset in cycle 1.
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 2'd3, 8'h00);   // cycle 0
        nextCycle();
        idle();                                                            // cycle 1
        checkOutput("mid_busy_before", busyL3, 4'b1000);
        rstN = 1'b0;
        #1;
        checkOutput("mid_busy_async", busyL3, 4'b0000);
        checkOutput("mid_ready_async", loadReadyL3, 1'b1);
        nextCycle();
        rstN = 1'b1;                                                       // cycle 2
        for (int c = 2; c <= 6; c++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0,
                          (c == 3) ? 8'hEE : 8'h00);
            checkOutput("mid_writeEn", writeEnL3, 1'b0);
            nextCycle();
        end
        checkOutput("mid_writeEn_c7", writeEnL3, 1'b0);
        checkOutput("mid_busy_end", busyL3, 4'b0000);
        checkOutput("mid_ready_end", loadReadyL3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
